// File: rtl/memarb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
// Requester 0 is the CPU, requester 1 is the host/loader.
package memarb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam int unsigned REQ_CPU  = 0;
    localparam int unsigned REQ_HOST = 1;

    typedef enum logic [1:0] {
        LK_IDLE = 2'd0,
        LK_CPU  = 2'd1,
        LK_HOST = 2'd2
    } lock_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: 2-way round-robin grant; the loser of the last granted transfer is preferred.
// Latency: grant is combinational from req; pointer moves on the clock after an enabled grant.
// Backpressure: none internally; a requester not granted simply sees gnt low.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic [1:0] gnt
);

    // prio = 1 means requester 1 wins a tie
    logic prio;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (upd_en && (|gnt)) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between CPU and host; MEMARB_LOCK_EN adds grant locking.
// Latency: request/memory path combinational; read data returns one cycle after acceptance.
// Backpressure: req_ready low stalls a requester; it may drop req_valid at any time.
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    input  logic [1:0]             req_lock,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic [1:0] grant;
    logic       upd_en;
    logic       rd_issue;
    logic       rd_pend;
    logic       rd_who;

`ifdef MEMARB_LOCK_EN
    lock_state_e lock_state;
    lock_state_e lock_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= LK_IDLE;
        end else begin
            lock_state <= lock_nxt;
        end
    end

    // While locked, only the owner is presented to the arbiter
    always_comb begin
        arb_req = req_valid;
        case (lock_state)
            LK_CPU:  arb_req = req_valid & 2'b01;
            LK_HOST: arb_req = req_valid & 2'b10;
            default: arb_req = req_valid;
        endcase
    end

    always_comb begin
        lock_nxt = lock_state;
        upd_en   = 1'b0;
        case (lock_state)
            LK_IDLE: begin
                if (grant[REQ_CPU] && req_lock[REQ_CPU]) begin
                    lock_nxt = LK_CPU;
                end else if (grant[REQ_HOST] && req_lock[REQ_HOST]) begin
                    lock_nxt = LK_HOST;
                end else begin
                    upd_en = 1'b1;
                end
            end
            LK_CPU: begin
                if (grant[REQ_CPU] && !req_lock[REQ_CPU]) begin
                    lock_nxt = LK_IDLE;
                    upd_en   = 1'b1;
                end
            end
            LK_HOST: begin
                if (grant[REQ_HOST] && !req_lock[REQ_HOST]) begin
                    lock_nxt = LK_IDLE;
                    upd_en   = 1'b1;
                end
            end
            default: lock_nxt = LK_IDLE;
        endcase
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign arb_req     = req_valid;
    assign upd_en      = 1'b1;
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (arb_req),
        .upd_en (upd_en),
        .gnt    (arb_gnt)
    );

    // Nothing is granted while reset is held
    assign grant     = arb_gnt & {2{rst_n}};
    assign req_ready = grant;
    assign mem_we    = |(grant & req_we);
    assign rd_issue  = |(grant & ~req_we);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant[REQ_CPU]) begin
            mem_addr  = req_addr[REQ_CPU];
            mem_wdata = req_wdata[REQ_CPU];
        end else if (grant[REQ_HOST]) begin
            mem_addr  = req_addr[REQ_HOST];
            mem_wdata = req_wdata[REQ_HOST];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_who  <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            rd_who  <= grant[REQ_HOST];
        end
    end

    assign rsp_valid = {rd_pend & rd_who, rd_pend & ~rd_who};
    assign rsp_rdata = rd_pend ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read memory model.
// Lock scenario is selected by MEMARB_LOCK_EN, matching the DUT build.
module tb_mem_port_arbiter;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [1:0][3:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      req_lock;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [7:0]      rsp_rdata;
    logic            mem_we;
    logic [3:0]      mem_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;

    logic [7:0] mem [16];

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents are preset to 0x10+addr while reset is held
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // One cycle: drive just after the rising edge, return at the falling edge for checking
    task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clk);
        #1;
        req_valid    = v;
        req_we       = we;
        req_lock     = lk;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        #4;
    endtask

    task automatic idle();
        cyc(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11; req_we = 2'b11; req_lock = 2'b00;
        req_addr[0] = 4'd1; req_addr[1] = 4'd2;
        req_wdata[0] = 8'h11; req_wdata[1] = 8'h22;
        @(posedge clk);
        #4;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        rst_n = 1'b1;
        req_valid = 2'b00; req_we = 2'b00;
        idle();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL post_reset_ready: got %b want 00", req_ready); end
    endtask

    task automatic test_write_read();
        cyc(2'b01, 2'b01, 2'b00, 4'd3, 4'd0, 8'hA5, 8'h00);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", req_ready); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 4'd3) begin errors++; $display("FAIL wr_mem_addr: got %h want 3", mem_addr); end
        checks++; if (mem_wdata !== 8'hA5) begin errors++; $display("FAIL wr_mem_wdata: got %h want a5", mem_wdata); end
        cyc(2'b10, 2'b00, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_ready: got %b want 10", req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 4'd3) begin errors++; $display("FAIL rd_mem_addr: got %h want 3", mem_addr); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b want 00", rsp_valid); end
        idle();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL raw_rsp_valid: got %b want 10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL raw_rsp_rdata: got %h want a5", rsp_rdata); end
        idle();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rsp_one_cycle: got %b want 00", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rsp_rdata_idle: got %h want 00", rsp_rdata); end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        prev_g = 2'b00;
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 2'b00, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL alt_ready[%0d]: got %b want %b", k, req_ready, exp_g); end
            if (k > 0) begin
                checks++; if (rsp_valid !== prev_g) begin errors++; $display("FAIL alt_rsp_valid[%0d]: got %b want %b", k, rsp_valid, prev_g); end
                checks++; if (rsp_rdata !== (prev_g == 2'b01 ? 8'h11 : 8'h12)) begin errors++; $display("FAIL alt_rsp_rdata[%0d]: got %h", k, rsp_rdata); end
            end
            prev_g = exp_g;
        end
        idle();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL alt_last_valid: got %b want 10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h12) begin errors++; $display("FAIL alt_last_rdata: got %h want 12", rsp_rdata); end
    endtask

    task automatic test_single();
        for (int k = 0; k < 3; k++) begin
            cyc(2'b10, 2'b00, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00);
            checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL single_ready[%0d]: got %b want 10", k, req_ready); end
            if (k > 0) begin
                checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h17) begin errors++; $display("FAIL single_rsp[%0d]: got %b/%h want 10/17", k, rsp_valid, rsp_rdata); end
            end
        end
        idle();
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h17) begin errors++; $display("FAIL single_last: got %b/%h want 10/17", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_drop();
        cyc(2'b11, 2'b11, 2'b00, 4'd9, 4'd9, 8'h99, 8'h77);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL drop_ready: got %b want 01", req_ready); end
        checks++; if (mem_wdata !== 8'h99) begin errors++; $display("FAIL drop_wdata: got %h want 99", mem_wdata); end
        idle();
        checks++; if (req_ready !== 2'b00 || mem_we !== 1'b0) begin errors++; $display("FAIL idle_ctrl: got %b/%b want 00/0", req_ready, mem_we); end
        checks++; if (mem_addr !== 4'd0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL idle_mem_zero: got %h/%h want 0/00", mem_addr, mem_wdata); end
        cyc(2'b11, 2'b00, 2'b00, 4'd9, 4'd9, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL drop_rr_ready: got %b want 10", req_ready); end
        idle();
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h99) begin errors++; $display("FAIL drop_rsp: got %b/%h want 10/99", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_lock();
`ifdef MEMARB_LOCK_EN
        cyc(2'b11, 2'b00, 2'b01, 4'd5, 4'd5, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_a_ready: got %b want 01", req_ready); end
        cyc(2'b11, 2'b01, 2'b00, 4'd5, 4'd5, 8'h5A, 8'h00);
        checks++; if (req_ready !== 2'b01 || mem_we !== 1'b1) begin errors++; $display("FAIL lock_b_ctrl: got %b/%b want 01/1", req_ready, mem_we); end
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h15) begin errors++; $display("FAIL lock_b_rsp: got %b/%h want 01/15", rsp_valid, rsp_rdata); end
        cyc(2'b11, 2'b00, 2'b00, 4'd5, 4'd5, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_c_ready: got %b want 10", req_ready); end
        idle();
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h5A) begin errors++; $display("FAIL lock_d_rsp: got %b/%h want 10/5a", rsp_valid, rsp_rdata); end
        cyc(2'b10, 2'b00, 2'b10, 4'd0, 4'd5, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_e_ready: got %b want 10", req_ready); end
        cyc(2'b01, 2'b00, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL lock_hold_ready: got %b want 00", req_ready); end
        cyc(2'b11, 2'b00, 2'b00, 4'd5, 4'd5, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_g_ready: got %b want 10", req_ready); end
        cyc(2'b01, 2'b00, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_h_ready: got %b want 01", req_ready); end
        idle();
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h5A) begin errors++; $display("FAIL lock_h_rsp: got %b/%h want 01/5a", rsp_valid, rsp_rdata); end
`else
        cyc(2'b11, 2'b00, 2'b11, 4'd1, 4'd2, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL nolock_a_ready: got %b want 01", req_ready); end
        cyc(2'b11, 2'b00, 2'b11, 4'd1, 4'd2, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL nolock_b_ready: got %b want 10", req_ready); end
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h11) begin errors++; $display("FAIL nolock_b_rsp: got %b/%h want 01/11", rsp_valid, rsp_rdata); end
        idle();
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h12) begin errors++; $display("FAIL nolock_c_rsp: got %b/%h want 10/12", rsp_valid, rsp_rdata); end
`endif
    endtask

    task automatic test_reset_mid();
        cyc(2'b01, 2'b00, 2'b00, 4'd1, 4'd0, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ready: got %b want 01", req_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        #4;
        checks++; if (rsp_valid !== 2'b00 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL mid_rsp_in_reset: got %b/%h want 00/00", rsp_valid, rsp_rdata); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle();
        checks++; if (rsp_valid !== 2'b00 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL mid_rsp_after: got %b/%h want 00/00", rsp_valid, rsp_rdata); end
        cyc(2'b10, 2'b00, 2'b00, 4'd0, 4'd2, 8'h00, 8'h00);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mid_resume_ready: got %b want 10", req_ready); end
        idle();
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h12) begin errors++; $display("FAIL mid_resume_rsp: got %b/%h want 10/12", rsp_valid, rsp_rdata); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_single();
        test_drop();
        test_lock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width (16 words).
REQ-002 Parameter DATA_W, default 8, memory word width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester access request (index 0 = CPU, 1 = host/loader).
REQ-006 req_we  input  2  per-requester write (1) / read (0).
REQ-007 req_addr  input  2xADDR_W  per-requester address.
REQ-008 req_wdata  input  2xDATA_W  per-requester write data.
REQ-009 req_lock  input  2  per-requester hold-grant request (used only when MEMARB_LOCK_EN is defined).
REQ-010 req_ready  output  2  request accepted this cycle (one-hot or zero).
REQ-011 rsp_valid  output  2  read data valid for that requester.
REQ-012 rsp_rdata  output  DATA_W  read data, shared by both requesters.
REQ-013 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  memory port; mem_rdata  input  DATA_W; memory has 1-cycle registered read.

Function
REQ-014 At most one access issued to memory per cycle; a transfer occurs when req_valid[i] && req_ready[i].
REQ-015 req_ready is combinational from req_valid and arbiter state; req_valid is never required to wait on req_ready.
REQ-016 Round-robin: the requester that did not win the last transfer has priority when both are valid; after reset requester 0 has priority.
REQ-017 Single valid requester is granted in the same cycle, with no idle bubble.
REQ-018 mem_* outputs are combinational mux of the granted request; mem_we = 1 only for an accepted write; with no grant, mem_we = 0 and mem_addr/mem_wdata = 0.
REQ-019 Accepted read: rsp_valid[i] high exactly one cycle, the cycle after acceptance; rsp_rdata = mem_rdata in that cycle; rsp_rdata = 0 when no rsp_valid.
REQ-020 Writes produce no response.
REQ-021 Back-to-back reads (any mix of requesters) sustain one read per cycle; responses return in acceptance order.
REQ-022 Read in cycle N+1 of an address written in cycle N returns the new data; same-cycle read/write does not occur (single port).
REQ-023 Requester dropping req_valid without acceptance is legal; no state is changed.

Reset
REQ-024 On rst_n low: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, mem_we = 0, priority pointer = requester 0, lock FSM = IDLE, pending-read flag cleared.
REQ-025 Reset asserted mid-read discards the response; no rsp_valid after reset release for reads issued before it.
REQ-026 Outputs valid from the first clock edge after rst_n deasserts.

Configuration
REQ-027 Macro MEMARB_LOCK_EN defined: FSM states IDLE and LOCKED(owner); transfer with req_lock[i]=1 in IDLE -> LOCKED(i); in LOCKED only owner may be granted; owner transfer with req_lock=0 -> IDLE; owner req_valid low keeps LOCKED.
REQ-028 MEMARB_LOCK_EN defined: other requester stalls (req_ready=0) while LOCKED; round-robin pointer updates only on return to IDLE.
REQ-029 MEMARB_LOCK_EN undefined: req_lock ignored, no lock FSM logic, pure round-robin.

Structure
REQ-030 Shared package memarb_pkg holds ADDR_W/DATA_W defaults, requester index constants (REQ_CPU=0, REQ_HOST=1) and lock FSM state enum.
REQ-031 One sub-module rr_arb2 (2-way round-robin grant with pointer update enable); the memory array is external.

Verification
REQ-032 Reset, write 0xA5 to addr 3 by req0, read addr 3 by req1 next cycle -> rsp_valid=2'b10 one cycle later, rsp_rdata=0xA5.
REQ-033 Both requesters valid reading addrs 1/2 for 4 cycles -> grants alternate 0,1,0,1; responses in order, one per cycle.
REQ-034 Only req1 valid for 3 cycles -> req_ready=2'b10 each cycle, no bubbles.
REQ-035 MEMARB_LOCK_EN: req0 read with lock=1 at addr 5, write 0x5A with lock=0 while req1 valid -> req1 stalled 2 cycles then granted; addr 5 reads 0x5A.
REQ-036 Read accepted, rst_n pulsed low in response cycle -> rsp_valid=0 and rsp_rdata=0 during and after reset.
